// File: rtl/vend_ctrl.sv
// Vending credit controller: coin accumulation, vend with price check, cancel, optional change return.
// Optional feature: define CHANGE_RETURN_EN to enable the CHANGE state and ret_q/ret_d/ret_n coin return.
module vend_ctrl #(
  parameter int MAX_CREDIT = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_q,
  input  logic       coin_d,
  input  logic       coin_n,
  input  logic [6:0] price,
  input  logic       vend_req,
  input  logic       cancel,
  output logic [6:0] credit,
  output logic       dispense,
  output logic       deny,
  output logic       coin_reject,
  output logic       ret_q,
  output logic       ret_d,
  output logic       ret_n,
  output logic       busy
);

`ifdef CHANGE_RETURN_EN
  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCUM, VEND} state_t;
`endif

  state_t state;

  function automatic logic [7:0] coin_sum(input logic q, input logic d, input logic n);
    return (q ? 8'd25 : 8'd0) + (d ? 8'd10 : 8'd0) + (n ? 8'd5 : 8'd0);
  endfunction

  function automatic logic price_ok(input logic [6:0] p, input logic [6:0] c);
    return (p != 7'd0) && ((p % 7'd5) == 7'd0) && (c >= p);
  endfunction

  logic       any_coin;
  logic [7:0] sum_total;
  logic       fits;

  assign any_coin  = coin_q | coin_d | coin_n;
  assign sum_total = {1'b0, credit} + coin_sum(coin_q, coin_d, coin_n);
  assign fits      = (sum_total <= 8'(MAX_CREDIT));

`ifndef CHANGE_RETURN_EN
  assign ret_q = 1'b0;
  assign ret_d = 1'b0;
  assign ret_n = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= 7'd0;
      dispense    <= 1'b0;
      deny        <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
`ifdef CHANGE_RETURN_EN
      ret_q       <= 1'b0;
      ret_d       <= 1'b0;
      ret_n       <= 1'b0;
`endif
    end else begin
      dispense    <= 1'b0;
      deny        <= 1'b0;
      coin_reject <= 1'b0;
`ifdef CHANGE_RETURN_EN
      ret_q       <= 1'b0;
      ret_d       <= 1'b0;
      ret_n       <= 1'b0;
`endif
      case (state)
        IDLE, ACCUM: begin
          // cancel beats vend_req beats coins; coins in a request cycle are bounced
          if (cancel) begin
            coin_reject <= any_coin;
            if (credit != 7'd0) begin
`ifdef CHANGE_RETURN_EN
              state <= CHANGE;
              busy  <= 1'b1;
`else
              credit <= 7'd0;
              state  <= IDLE;
`endif
            end
          end else if (vend_req) begin
            coin_reject <= any_coin;
            if (price_ok(price, credit)) begin
              state    <= VEND;
              credit   <= credit - price;
              dispense <= 1'b1;
              busy     <= 1'b1;
            end else begin
              deny <= 1'b1;
            end
          end else if (any_coin) begin
            if (fits) begin
              credit <= sum_total[6:0];
              state  <= ACCUM;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        VEND: begin
          coin_reject <= any_coin;
`ifdef CHANGE_RETURN_EN
          if (credit != 7'd0) begin
            state <= CHANGE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= (credit != 7'd0) ? ACCUM : IDLE;
          busy  <= 1'b0;
`endif
        end
`ifdef CHANGE_RETURN_EN
        CHANGE: begin
          // greedy return, one coin per cycle; leave once credit is already zero
          coin_reject <= any_coin;
          if (credit >= 7'd25) begin
            ret_q  <= 1'b1;
            credit <= credit - 7'd25;
          end else if (credit >= 7'd10) begin
            ret_d  <= 1'b1;
            credit <= credit - 7'd10;
          end else if (credit != 7'd0) begin
            ret_n  <= 1'b1;
            credit <= credit - 7'd5;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: timeline model of credit/pulse outputs plus literal spot checks.
module tb_vend_ctrl;
  localparam int MAXC = 100;

  logic       clk;
  logic       reset;
  logic       coin_q, coin_d, coin_n;
  logic [6:0] price;
  logic       vend_req, cancel;
  logic [6:0] credit;
  logic       dispense, deny, coin_reject;
  logic       ret_q, ret_d, ret_n, busy;

  int checks   = 0;
  int failures = 0;

  vend_ctrl #(.MAX_CREDIT(MAXC)) dut (
    .clk(clk), .reset(reset),
    .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
    .price(price), .vend_req(vend_req), .cancel(cancel),
    .credit(credit), .dispense(dispense), .deny(deny), .coin_reject(coin_reject),
    .ret_q(ret_q), .ret_d(ret_d), .ret_n(ret_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: current credit plus a queue of already-determined future output cycles
  typedef struct {
    int credit;
    bit disp;
    bit rq;
    bit rd;
    bit rn;
    bit busy;
  } ent_t;

  ent_t sched[$];
  int   m_credit;
  int   e_credit;
  bit   e_disp, e_deny, e_rej, e_rq, e_rd, e_rn, e_busy;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic push_change(input int c);
    int r;
    r = c;
    while (r > 0) begin
      if (r >= 25) begin
        r -= 25;
        sched.push_back(ent_t'{r, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      end else if (r >= 10) begin
        r -= 10;
        sched.push_back(ent_t'{r, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
      end else begin
        r -= 5;
        sched.push_back(ent_t'{r, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      end
    end
    sched.push_back(ent_t'{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic model_step(input bit q, input bit d, input bit n, input int p, input bit v, input bit c);
    int   sum;
    bit   any;
    ent_t e;
    sum = (q ? 25 : 0) + (d ? 10 : 0) + (n ? 5 : 0);
    any = (sum > 0);
    e_deny = 0; e_rej = 0; e_disp = 0; e_rq = 0; e_rd = 0; e_rn = 0;
    if (sched.size() > 0) begin
      e = sched.pop_front();
      m_credit = e.credit;
      e_disp = e.disp; e_rq = e.rq; e_rd = e.rd; e_rn = e.rn; e_busy = e.busy;
      e_rej = any;
    end else begin
      e_busy = 0;
      if (c) begin
        e_rej = any;
        if (m_credit > 0) begin
`ifdef CHANGE_RETURN_EN
          e_busy = 1;
          push_change(m_credit);
`else
          m_credit = 0;
`endif
        end
      end else if (v) begin
        e_rej = any;
        if (p != 0 && (p % 5) == 0 && m_credit >= p) begin
          m_credit -= p;
          e_disp = 1;
          e_busy = 1;
`ifdef CHANGE_RETURN_EN
          if (m_credit > 0) begin
            sched.push_back(ent_t'{m_credit, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
            push_change(m_credit);
          end else begin
            sched.push_back(ent_t'{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
          end
`else
          sched.push_back(ent_t'{m_credit, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`endif
        end else begin
          e_deny = 1;
        end
      end else if (any) begin
        if (m_credit + sum <= MAXC) m_credit += sum;
        else e_rej = 1;
      end
    end
    e_credit = m_credit;
  endtask

  task automatic compare_outputs();
    logic [13:0] got, expv;
    got  = {credit, dispense, deny, coin_reject, ret_q, ret_d, ret_n, busy};
    expv = {7'(e_credit), e_disp, e_deny, e_rej, e_rq, e_rd, e_rn, e_busy};
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL cycle@%0t {credit,disp,deny,rej,rq,rd,rn,busy}: got %h expected %h", $time, got, expv);
    end
  endtask

  task automatic cyc(input bit q, input bit d, input bit n, input int p, input bit v, input bit c);
    @(negedge clk);
    coin_q = q; coin_d = d; coin_n = n; price = 7'(p); vend_req = v; cancel = c;
    model_step(q, d, n, p, v, c);
    @(posedge clk);
    #1;
    compare_outputs();
    coin_q = 0; coin_d = 0; coin_n = 0; price = 7'd0; vend_req = 0; cancel = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_cycle_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_credit", 16'(credit), 16'd0);
    chk("async_rst_busy", 16'(busy), 16'd0);
    chk("async_rst_rets", 16'({ret_q, ret_d, ret_n, dispense}), 16'd0);
    m_credit = 0;
    sched.delete();
    @(posedge clk);
    #1;
    chk("rst_hold_credit", 16'(credit), 16'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    coin_q = 0; coin_d = 0; coin_n = 0; price = 7'd0; vend_req = 0; cancel = 0;
    m_credit = 0;
    #2;
    chk("reset_credit", 16'(credit), 16'd0);
    chk("reset_pulses", 16'({dispense, deny, coin_reject, ret_q, ret_d, ret_n, busy}), 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // coin accumulation
    cyc(1, 0, 0, 0, 0, 0); chk("credit_25", 16'(credit), 16'd25);
    cyc(1, 0, 0, 0, 0, 0); chk("credit_50", 16'(credit), 16'd50);
    cyc(0, 1, 0, 0, 0, 0); chk("credit_60", 16'(credit), 16'd60);
    cyc(0, 0, 1, 0, 0, 0); chk("credit_65", 16'(credit), 16'd65);

    // exact-price vend
    cyc(0, 0, 0, 65, 1, 0);
    chk("vend65_dispense", 16'(dispense), 16'd1);
    chk("vend65_credit", 16'(credit), 16'd0);
    idle(1);
    chk("vend65_after_busy", 16'(busy), 16'd0);
    chk("vend65_no_ret", 16'({ret_q, ret_d, ret_n}), 16'd0);

    // vend with change: 100 - 60 = 40
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    chk("credit_100", 16'(credit), 16'd100);
    cyc(0, 0, 0, 60, 1, 0);
    chk("vend60_credit", 16'(credit), 16'd40);
    idle(2);
`ifdef CHANGE_RETURN_EN
    chk("vend60_first_ret_q", 16'(ret_q), 16'd1);
`endif
    idle(4);
`ifdef CHANGE_RETURN_EN
    chk("vend60_final_credit", 16'(credit), 16'd0);
`else
    chk("vend60_retained", 16'(credit), 16'd40);
`endif
    cyc(0, 0, 0, 0, 0, 1);
    idle(8);

    // ceiling: 95 + 10 rejected, 95 + 5 accepted, 100 + 5 rejected
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    chk("credit_95", 16'(credit), 16'd95);
    cyc(0, 1, 0, 0, 0, 0);
    chk("over_reject", 16'(coin_reject), 16'd1);
    chk("over_credit", 16'(credit), 16'd95);
    cyc(0, 0, 1, 0, 0, 0);
    chk("exact_fit_100", 16'(credit), 16'd100);
    cyc(0, 0, 1, 0, 0, 0);
    chk("full_reject_credit", 16'(credit), 16'd100);
    cyc(0, 0, 0, 0, 0, 1);
    idle(10);
    chk("cleared_credit", 16'(credit), 16'd0);

    // denials: insufficient credit, price not a multiple of 5
    cyc(1, 0, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 35, 1, 0);
    chk("deny35", 16'(deny), 16'd1);
    chk("deny35_credit", 16'(credit), 16'd30);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 33, 1, 0);
    chk("deny33", 16'(deny), 16'd1);

    // cancel with simultaneous coin at credit 40
    cyc(1, 0, 0, 0, 0, 1);
    chk("cancel_coin_reject", 16'(coin_reject), 16'd1);
`ifndef CHANGE_RETURN_EN
    chk("cancel_cleared", 16'(credit), 16'd0);
`endif
    idle(6);
    chk("cancel_done_credit", 16'(credit), 16'd0);

    // multi-coin cycle, vend with coin bounced, zero price denied
    cyc(1, 1, 1, 0, 0, 0);
    chk("multi_coin_40", 16'(credit), 16'd40);
    cyc(0, 0, 1, 40, 1, 0);
    chk("vend_coin_reject", 16'(coin_reject), 16'd1);
    chk("vend_coin_dispense", 16'(dispense), 16'd1);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("deny_price0", 16'(deny), 16'd1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(5);

    // requests and coins while busy, then reset in the middle of the sequence
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 40, 1, 0);
    cyc(0, 1, 0, 20, 1, 1);
    idle(1);
    mid_cycle_reset();

    // first edge after reset release is processed normally
    cyc(1, 0, 0, 0, 0, 0);
    chk("post_reset_25", 16'(credit), 16'd25);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter MAX_CREDIT, default 100, meaning the credit ceiling in cents (multiple of 5, at most 127).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets).
REQ-004 SHALL have ports coin_q, coin_d, coin_n, input, 1 bit each: single-cycle coin pulses of 25, 10 and 5 cents.
REQ-005 SHALL have port price, input, 7 bits: item price in cents, sampled when vend_req=1.
REQ-006 SHALL have ports vend_req and cancel, input, 1 bit each: single-cycle requests.
REQ-007 SHALL have port credit, output, 7 bits: the registered current credit in cents.
REQ-008 SHALL have ports dispense, deny and coin_reject, output, 1 bit each: registered single-cycle pulses.
REQ-009 SHALL have ports ret_q, ret_d, ret_n, output, 1 bit each: registered change-coin pulses, at most one per cycle.
REQ-010 SHALL have port busy, output, 1 bit: 1 while in state VEND or CHANGE.

Function
REQ-011 SHALL implement the states IDLE (credit=0), ACCUM (credit>0), VEND and CHANGE.
REQ-012 In IDLE/ACCUM, a cycle's coin value SHALL be the sum of the asserted coin inputs (0..40); the sum SHALL be added to credit at the next edge only if credit+sum<=MAX_CREDIT.
REQ-013 If credit+sum>MAX_CREDIT, all coins of that cycle SHALL be rejected: credit is unchanged and coin_reject=1 for the next cycle.
REQ-014 Priority within a cycle SHALL be cancel > vend_req > coins; coins arriving in a vend_req or cancel cycle SHALL be rejected (coin_reject pulse).
REQ-015 On vend_req with credit>=price, price!=0 and price a multiple of 5, the block SHALL enter VEND at the next edge, with credit<=credit-price.
REQ-016 Any other vend_req SHALL leave credit unchanged and SHALL pulse deny for one cycle one edge later.
REQ-017 In VEND, dispense=1 for exactly that one cycle, giving a latency of one cycle from vend_req to dispense.
REQ-018 From VEND, the block SHALL go to CHANGE if change return is enabled and credit>0, otherwise to ACCUM if credit>0, otherwise to IDLE.
REQ-019 On cancel with credit>0, the block SHALL go to CHANGE; cancel with credit=0 SHALL be ignored.
REQ-020 In CHANGE, each cycle SHALL emit the largest coin not exceeding the credit (ret_q if >=25, else ret_d if >=10, else ret_n) and subtract its value from credit.
REQ-021 CHANGE SHALL exit to IDLE on the cycle after credit reaches 0.
REQ-022 In VEND/CHANGE, coins SHALL be rejected (coin_reject pulse), and vend_req and cancel SHALL be ignored with no deny pulse.
REQ-023 Credit SHALL never exceed MAX_CREDIT, never underflow, and always remain a multiple of 5.

Reset
REQ-024 On reset=0, the block SHALL immediately go to IDLE, with credit=0 and all pulse outputs and busy at 0, regardless of state; an in-progress vend or change sequence SHALL be abandoned.
REQ-025 After reset=1, the first edge SHALL process inputs normally.

Configuration
REQ-026 With macro CHANGE_RETURN_EN defined, CHANGE SHALL be reachable and behave as REQ-018..REQ-021.
REQ-027 Without CHANGE_RETURN_EN, the CHANGE state SHALL be absent and ret_q/ret_d/ret_n SHALL be tied to 0.
REQ-028 Without CHANGE_RETURN_EN, remaining credit after VEND SHALL be retained (state ACCUM), and cancel with credit>0 SHALL clear credit to 0 at the next edge (state IDLE).

Verification
REQ-029 Reset, then coin_q, coin_q, coin_d, coin_n on separate cycles -> credit reads 25, 50, 60, 65.
REQ-030 Credit 65, price=65, vend_req -> dispense pulse on the next cycle, credit=0, state IDLE, no ret pulses.
REQ-031 (CHANGE_RETURN_EN) Credit 100, price=60, vend_req -> dispense, then ret_q, ret_d, ret_n on consecutive cycles, then IDLE with credit=0.
REQ-032 Credit 95, coin_d -> coin_reject, credit stays 95; credit 30, price=35 vend_req -> deny, credit stays 30; price=33 with credit 40 -> deny.
REQ-033 Credit 40, cancel and coin_q in the same cycle -> coin_reject plus change ret_q, ret_d, ret_n (CHANGE_RETURN_EN); without the macro, credit=0 next cycle.
REQ-034 Reset asserted in the middle of the CHANGE sequence -> credit=0, busy=0 and all ret outputs 0 immediately, without waiting for clk.
